// File: rtl/unpacked_lane_collector_if.sv
// Handshake bundle for the lane collector: word stream in, unpacked lane frame out.
interface unpacked_lane_collector_if #(
    parameter int M  = 2,
    parameter int W  = 1,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data [M];
    logic [CW-1:0] frames_out;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, frames_out
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, frames_out
    );
endinterface

// File: rtl/unpacked_lane_collector.sv
// Assembles M consecutive W-bit words into an unpacked lane frame; a collect
// buffer plus an output register give two frames of slack under backpressure.
module unpacked_lane_collector #(
    parameter int M  = 2,
    parameter int W  = 1,
    parameter int CW = 16
) (
    input  logic                     clock,
    input  logic                     rstn,
    input  logic                     clear,
    unpacked_lane_collector_if.slave bus
);
    localparam int              CNTW     = $clog2(M + 1);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(M - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(M);

    logic [CNTW-1:0] cnt;
    logic [W-1:0]    coll   [M];
    logic [W-1:0]    outReg [M];
    logic            outValid;
    logic [CW-1:0]   frameCount;

    logic inReady;
    logic accept;
    logic slotFree;
    logic outFire;
    logic loadDirect;
    logic loadPending;
    logic frameLoad;

    // in_ready looks only at the registered count, never at out_ready.
    assign inReady     = (cnt != FULL_CNT);
    assign accept      = bus.in_valid & inReady;
    assign slotFree    = ~outValid | bus.out_ready;
    assign outFire     = outValid & bus.out_ready;
    assign loadDirect  = accept & (cnt == LAST_IDX) & slotFree;
    assign loadPending = (cnt == FULL_CNT) & slotFree;
    assign frameLoad   = loadDirect | loadPending;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            outValid   <= 1'b0;
            frameCount <= '0;
        end else if (clear) begin
            cnt        <= '0;
            outValid   <= 1'b0;
            frameCount <= '0;
        end else begin
            if (outFire)
                frameCount <= frameCount + 1'b1;

            if (frameLoad)
                outValid <= 1'b1;
            else if (outFire)
                outValid <= 1'b0;

            if (frameLoad)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 1'b1;
        end
    end

    // NOTE: lane storage is reset because the zeroed frame is visible on out_data.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < M; k++) begin
                coll[k]   <= '0;
                outReg[k] <= '0;
            end
        end else if (!clear) begin
            if (accept) begin
                for (int k = 0; k < M; k++) begin
                    if (cnt == CNTW'(k))
                        coll[k] <= bus.in_data;
                end
            end

            // A direct load bypasses coll for the last lane of the frame.
            if (loadDirect) begin
                for (int k = 0; k < M - 1; k++)
                    outReg[k] <= coll[k];
                outReg[M-1] <= bus.in_data;
            end else if (loadPending) begin
                for (int k = 0; k < M; k++)
                    outReg[k] <= coll[k];
            end
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid;
    assign bus.out_data   = outReg;
    assign bus.frames_out = frameCount;
endmodule

// File: tb/tb_unpacked_lane_collector.sv
// Self-checking bench: M=4/W=8/CW=4 instance against a frame-queue model,
// plus a default-parameter instance for the M=2/W=1 case.
module tb_unpacked_lane_collector;
    logic clock = 1'b0;
    logic rstn;
    logic clearA;
    logic clearB;

    int tests      = 0;
    int fails      = 0;
    int delCount   = 0;
    int dutAccepts = 0;

    // Reference model: completed-but-undelivered frames, and the partial frame.
    logic [31:0] frameQ [$];
    logic [7:0]  partQ  [$];

    unpacked_lane_collector_if #(.M(4), .W(8), .CW(4))  busA ();
    unpacked_lane_collector_if #(.M(2), .W(1), .CW(16)) busB ();

    unpacked_lane_collector #(.M(4), .W(8), .CW(4)) dutA (
        .clock (clock),
        .rstn  (rstn),
        .clear (clearA),
        .bus   (busA)
    );

    unpacked_lane_collector dutB (
        .clock (clock),
        .rstn  (rstn),
        .clear (clearB),
        .bus   (busB)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        frameQ.delete();
        partQ.delete();
        delCount = 0;
    endtask

    // Up to two complete frames are buffered; one is visible whenever any exists.
    task automatic checkA();
        check("a_in_ready",  32'(busA.in_ready),   32'(frameQ.size() < 2));
        check("a_out_valid", 32'(busA.out_valid),  32'(frameQ.size() >= 1));
        check("a_frames",    32'(busA.frames_out), 32'(delCount % 16));
        if (frameQ.size() >= 1) begin
            for (int k = 0; k < 4; k++)
                check("a_lane", 32'(busA.out_data[k]), 32'(frameQ[0][8*k +: 8]));
        end
    endtask

    task automatic modelStep(input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                             output bit accepted);
        bit          readyNow;
        bit          validNow;
        logic [31:0] f;
        readyNow = frameQ.size() < 2;
        validNow = frameQ.size() >= 1;
        accepted = 1'b0;
        if (clr) begin
            modelReset();
        end else begin
            if (validNow && rdy) begin
                void'(frameQ.pop_front());
                delCount++;
            end
            if (v && readyNow) begin
                accepted = 1'b1;
                partQ.push_back(d);
                if (partQ.size() == 4) begin
                    f = {partQ[3], partQ[2], partQ[1], partQ[0]};
                    frameQ.push_back(f);
                    partQ.delete();
                end
            end
        end
    endtask

    // Called at a falling edge: check, drive, clock, update model, return at next falling edge.
    task automatic stepA(input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                         output bit accepted);
        checkA();
        busA.in_valid  = v;
        busA.in_data   = d;
        busA.out_ready = rdy;
        clearA         = clr;
        if (v && busA.in_ready && !clr)
            dutAccepts++;
        @(posedge clock);
        modelStep(v, d, rdy, clr, accepted);
        @(negedge clock);
    endtask

    initial begin
        bit   acc;
        int   idx;
        int   base;
        int   guard;
        logic [3:0] framesBefore;

        rstn           = 1'b0;
        clearA         = 1'b0;
        clearB         = 1'b0;
        busA.in_valid  = 1'b0;
        busA.in_data   = '0;
        busA.out_ready = 1'b0;
        busB.in_valid  = 1'b0;
        busB.in_data   = '0;
        busB.out_ready = 1'b0;
        modelReset();

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_in_ready",  32'(busA.in_ready),   32'd1);
        check("rst_out_valid", 32'(busA.out_valid),  32'd0);
        check("rst_frames",    32'(busA.frames_out), 32'd0);
        for (int k = 0; k < 4; k++)
            check("rst_lane", 32'(busA.out_data[k]), 32'd0);
        check("rst_b_valid", 32'(busB.out_valid), 32'd0);
        rstn = 1'b1;
        @(negedge clock);

        // Default parameters: bits 1,0 form out_data = {1,0}
        busB.in_valid = 1'b1;
        busB.in_data  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        busB.in_data = 1'b0;
        @(posedge clock);
        @(negedge clock);
        busB.in_valid = 1'b0;
        check("b_valid",  32'(busB.out_valid),   32'd1);
        check("b_lane0",  32'(busB.out_data[0]), 32'd1);
        check("b_lane1",  32'(busB.out_data[1]), 32'd0);
        check("b_frames", 32'(busB.frames_out),  32'd0);
        busB.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("b_frames_after", 32'(busB.frames_out), 32'd1);
        check("b_drained",      32'(busB.out_valid),  32'd0);

        // Streaming with out_ready held high
        for (int i = 0; i < 8; i++)
            stepA(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++)
            stepA(1'b0, 8'h00, 1'b1, 1'b0, acc);
        check("stream_frames", 32'(busA.frames_out), 32'd2);

        // Stall: 12 words offered with out_ready low
        base = dutAccepts;
        idx  = 0;
        for (int i = 0; i < 12; i++) begin
            stepA(1'b1, 8'h20 + 8'(idx), 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("stall_accepted", 32'(dutAccepts - base), 32'd8);
        check("stall_in_ready", 32'(busA.in_ready),     32'd0);
        check("stall_lane0",    32'(busA.out_data[0]),  32'h20);
        guard = 0;
        while (idx < 12 && guard < 20) begin
            stepA(1'b1, 8'h20 + 8'(idx), 1'b1, 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        check("stall_resume", 32'(idx), 32'd12);
        for (int i = 0; i < 4; i++)
            stepA(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Last-word accept in the same cycle as an output handshake
        for (int i = 0; i < 7; i++)
            stepA(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, acc);
        framesBefore = busA.frames_out;
        stepA(1'b1, 8'h47, 1'b1, 1'b0, acc);
        check("simul_valid",  32'(busA.out_valid),   32'd1);
        check("simul_frames", 32'(busA.frames_out),  32'(framesBefore + 4'd1));
        check("simul_lane0",  32'(busA.out_data[0]), 32'h44);

        // Clear at cnt=2 with an output frame waiting; handshakes in that cycle are dropped
        stepA(1'b1, 8'h50, 1'b0, 1'b0, acc);
        stepA(1'b1, 8'h51, 1'b0, 1'b0, acc);
        stepA(1'b1, 8'h52, 1'b1, 1'b1, acc);
        check("clear_valid",  32'(busA.out_valid),  32'd0);
        check("clear_frames", 32'(busA.frames_out), 32'd0);
        for (int i = 0; i < 4; i++)
            stepA(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0, acc);
        check("clear_lane0", 32'(busA.out_data[0]), 32'h60);
        stepA(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Randomised traffic with occasional clears
        for (int i = 0; i < 300; i++)
            stepA($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 49) == 0, acc);

        // Counter wrap: 17 frames on a 4-bit counter
        stepA(1'b0, 8'h00, 1'b1, 1'b1, acc);
        for (int i = 0; i < 68; i++)
            stepA(1'b1, 8'(i), 1'b1, 1'b0, acc);
        stepA(1'b0, 8'h00, 1'b1, 1'b0, acc);
        stepA(1'b0, 8'h00, 1'b1, 1'b0, acc);
        check("wrap_frames", 32'(busA.frames_out), 32'd1);

        // Asynchronous reset between edges with three words collected
        for (int i = 0; i < 3; i++)
            stepA(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0, acc);
        busA.in_valid  = 1'b0;
        busA.out_ready = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("arst_in_ready",  32'(busA.in_ready),   32'd1);
        check("arst_out_valid", 32'(busA.out_valid),  32'd0);
        check("arst_frames",    32'(busA.frames_out), 32'd0);
        for (int k = 0; k < 4; k++)
            check("arst_lane", 32'(busA.out_data[k]), 32'd0);
        modelReset();
        @(negedge clock);
        rstn = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 4; i++)
            stepA(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, acc);
        check("post_rst_lane0", 32'(busA.out_data[0]), 32'h80);
        check("post_rst_lane3", 32'(busA.out_data[3]), 32'h83);
        stepA(1'b0, 8'h00, 1'b1, 1'b0, acc);
        stepA(1'b0, 8'h00, 1'b0, 1'b0, acc);
        checkA();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
